// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART host adapter: byte width and TX FSM states.
package uart_host_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE = 2'b00,
    TX_LOAD = 2'b01,
    TX_HOLD = 2'b10
  } tx_state_t;

endpackage

// File: rtl/uart_host_fifo.sv
// Byte FIFO with first-word-fall-through output, used for both TX and RX.
// Push-when-full is ignored unless a pop happens in the same cycle, in which
// case both proceed and the count is unchanged. Pop-when-empty is ignored.
import uart_host_pkg::*;

module uart_host_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [BYTE_W-1:0]     din,
  input  logic                  pop,
  output logic [BYTE_W-1:0]     dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [BYTE_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; the slot is freed by the pop in the same cycle when full.
  // NOTE: the data array has no reset -- only pointers and count define which
  // entries are meaningful, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_if.sv
// Host-side adapter for the uartICE40 byte interface.
// TX: valid/ready bytes -> FIFO -> single-cycle load/d pulses honouring txbusy.
// RX: bytercvd/q -> FIFO -> valid/ready to the host, with a sticky overrun flag.
// Optional build macro UART_HOST_LEVELS_EN exposes the FIFO fill levels.
import uart_host_pkg::*;

module uart_host_if #(
  parameter int TXDEPTH_LOG2 = 2,
  parameter int RXDEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [BYTE_W-1:0]   rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                rx_overrun,
  input  logic                rx_overrun_clr,
  output logic                load,
  output logic [BYTE_W-1:0]   d,
  input  logic                txbusy,
  input  logic                bytercvd,
  input  logic [BYTE_W-1:0]   q
`ifdef UART_HOST_LEVELS_EN
  ,
  output logic [TXDEPTH_LOG2:0] tx_level,
  output logic [RXDEPTH_LOG2:0] rx_level
`endif
);

  tx_state_t             state;
  logic                  hold_first;
  logic                  tx_push;
  logic                  tx_pop;
  logic [BYTE_W-1:0]     tx_head;
  logic                  tx_full;
  logic                  tx_empty;
  logic [TXDEPTH_LOG2:0] tx_count;
  logic                  rx_push;
  logic                  rx_pop;
  logic                  rx_full;
  logic                  rx_empty;
  logic [RXDEPTH_LOG2:0] rx_count;
  logic                  rx_drop;

  // TX handshake: ready depends only on the registered fill state.
  assign tx_ready = ~tx_full;
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = (state == TX_LOAD);

  uart_host_fifo #(.DEPTH_LOG2(TXDEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (tx_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // RX path: the core pushes unconditionally; the FIFO resolves full+pop.
  assign rx_valid = ~rx_empty;
  assign rx_push  = bytercvd;
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_drop  = bytercvd & rx_full & ~rx_pop;

  uart_host_fifo #(.DEPTH_LOG2(RXDEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (q),
    .pop   (rx_pop),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

`ifdef UART_HOST_LEVELS_EN
  assign tx_level = tx_count;
  assign rx_level = rx_count;
`endif

  // Empty flag and count must always agree in both FIFOs.
  a_tx_empty_count: assert property (@(posedge clk) disable iff (rst)
    tx_empty == (tx_count == '0));
  a_rx_empty_count: assert property (@(posedge clk) disable iff (rst)
    rx_empty == (rx_count == '0));

  // Sticky overrun flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)                 rx_overrun <= 1'b0;
    else if (rx_drop)        rx_overrun <= 1'b1;
    else if (rx_overrun_clr) rx_overrun <= 1'b0;
  end

  // TX FSM with load/d registered from the next-state decision, so load is
  // high exactly during the TX_LOAD cycle and d carries the FIFO head then.
  // NOTE: all state here uses non-blocking assignment so every branch sees the
  // pre-edge values of state, hold_first and the FIFO flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= TX_IDLE;
      hold_first <= 1'b0;
      load       <= 1'b0;
      d          <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (!tx_empty && !txbusy) begin
            state <= TX_LOAD;
            load  <= 1'b1;
            d     <= tx_head;
          end
        end
        TX_LOAD: begin
          state      <= TX_HOLD;
          hold_first <= 1'b1;
        end
        TX_HOLD: begin
          // The core only raises txbusy the cycle after load, so the first
          // HOLD cycle cannot trust a low txbusy.
          if (hold_first) begin
            hold_first <= 1'b0;
          end else if (!txbusy) begin
            if (!tx_empty) begin
              state <= TX_LOAD;
              load  <= 1'b1;
              d     <= tx_head;
            end else begin
              state <= TX_IDLE;
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_if.sv
// Self-checking bench for uart_host_if with a small behavioural core model
// (txbusy pulse after every load) and TX/RX scoreboard queues.
module tb_uart_host_if;

  localparam int RXD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_overrun;
  logic       rx_overrun_clr = 1'b0;
  logic       load;
  logic [7:0] d;
  logic       txbusy;
  logic       bytercvd = 1'b0;
  logic [7:0] q = 8'h00;
`ifdef UART_HOST_LEVELS_EN
  logic [2:0] tx_level;
  logic [2:0] rx_level;
`endif

  logic busy_hold  = 1'b0;
  logic model_busy = 1'b0;
  int   busy_len   = 3;
  assign txbusy = busy_hold | model_busy;

  int   checks   = 0;
  int   failures = 0;
  int   loads    = 0;
  logic prev_load = 1'b0;
  logic exp_ovr   = 1'b0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  uart_host_if dut (
    .clk            (clk),
    .rst            (rst),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_overrun     (rx_overrun),
    .rx_overrun_clr (rx_overrun_clr),
    .load           (load),
    .d              (d),
    .txbusy         (txbusy),
    .bytercvd       (bytercvd),
    .q              (q)
`ifdef UART_HOST_LEVELS_EN
    ,
    .tx_level       (tx_level),
    .rx_level       (rx_level)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core model: txbusy rises the cycle after a load and stays for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (load) begin
        @(posedge clk);
        #1;
        model_busy = 1'b1;
        repeat (busy_len) tick();
        model_busy = 1'b0;
      end
    end
  end

  // Load monitor: order of bytes, no load while busy, never back-to-back.
  always @(negedge clk) begin
    if (!rst && load) begin
      loads++;
      if (tx_exp.size() == 0) check("tx_spurious_load", 1, 0);
      else                    check("tx_d", d, tx_exp.pop_front());
      check("tx_load_while_busy", txbusy, 0);
      check("tx_back_to_back", prev_load, 0);
    end
    prev_load = load;
  end

  task automatic tx_push(input logic [7:0] b);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      check("tx_push_timeout", 0, 1);
    end else begin
      tick();
      tx_exp.push_back(b);
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while ((tx_exp.size() != 0 || model_busy) && n < 600) begin
      tick();
      n++;
    end
    check("tx_drain", tx_exp.size(), 0);
    repeat (3) tick();
  endtask

  // One bytercvd pulse, optionally with a host pop and/or overrun clear.
  task automatic rx_byte(input logic [7:0] b, input logic with_pop, input logic with_clr);
    logic full_before;
    logic popping;
    full_before    = (rx_exp.size() == RXD);
    popping        = with_pop && (rx_exp.size() != 0);
    q              = b;
    bytercvd       = 1'b1;
    rx_ready       = with_pop;
    rx_overrun_clr = with_clr;
    if (popping) check("rx_data_pushpop", rx_data, rx_exp.pop_front());
    if (!full_before || popping) rx_exp.push_back(b);
    if (full_before && !popping) exp_ovr = 1'b1;
    else if (with_clr)           exp_ovr = 1'b0;
    tick();
    bytercvd       = 1'b0;
    rx_ready       = 1'b0;
    rx_overrun_clr = 1'b0;
    check("rx_overrun", rx_overrun, exp_ovr);
  endtask

  task automatic rx_pop();
    check("rx_valid_pop", rx_valid, 1);
    if (rx_exp.size() != 0) check("rx_data", rx_data, rx_exp.pop_front());
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int loads_before;

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_load", load, 0);
    check("rst_d", d, 8'h00);
    check("rst_overrun", rx_overrun, 0);
`ifdef UART_HOST_LEVELS_EN
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
`endif

    // 1: single byte latency -- accepted at edge N, load high in cycle N+2 only
    busy_len = 3;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_exp.push_back(8'hA5);
    check("t1_load_n1", load, 0);
    check("t1_tx_ready", tx_ready, 1);
    tick();
    check("t1_load_n2", load, 1);
    check("t1_d_n2", d, 8'hA5);
    tick();
    check("t1_load_n3", load, 0);
    wait_tx_idle();

    // 2: fill TX FIFO while the core is busy, then stream with long busy pulses
    busy_len  = 20;
    busy_hold = 1'b1;
    loads_before = loads;
    for (int i = 1; i <= 4; i++) tx_push(8'(i));
    check("t2_tx_ready_full", tx_ready, 0);
    tx_data  = 8'h05;
    tx_valid = 1'b1;
    repeat (3) tick();
    check("t2_tx_ready_held", tx_ready, 0);
    check("t2_no_load_busy", loads - loads_before, 0);
    busy_hold = 1'b0;
    tx_push(8'h05);
    wait_tx_idle();
    check("t2_load_count", loads - loads_before, 5);

    // 3: two received bytes drained in order
    rx_byte(8'h3C, 1'b0, 1'b0);
    rx_byte(8'h55, 1'b0, 1'b0);
    check("t3_rx_valid", rx_valid, 1);
    rx_pop();
    rx_pop();
    check("t3_rx_empty", rx_valid, 0);

    // 4: overrun drops the byte; set wins over a coincident clear
    for (int i = 0; i < 4; i++) rx_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    rx_byte(8'hEE, 1'b0, 1'b0);
    rx_byte(8'hEF, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) rx_pop();
    check("t4_rx_empty", rx_valid, 0);
    check("t4_overrun_sticky", rx_overrun, 1);
    rx_overrun_clr = 1'b1;
    tick();
    rx_overrun_clr = 1'b0;
    exp_ovr = 1'b0;
    check("t4_overrun_clr", rx_overrun, 0);

    // 5: push and pop together while full -- no overrun, count unchanged
    for (int i = 0; i < 4; i++) rx_byte(8'h20 + 8'(i), 1'b0, 1'b0);
    rx_byte(8'h77, 1'b1, 1'b0);
`ifdef UART_HOST_LEVELS_EN
    check("t5_rx_level", rx_level, 4);
`endif
    for (int i = 0; i < 4; i++) rx_pop();
    check("t5_rx_empty", rx_valid, 0);

    // 6: reset mid-transfer clears both paths; nothing more is loaded
    busy_len = 20;
    loads_before = loads;
    for (int i = 0; i < 4; i++) tx_push(8'hB0 + 8'(i));
    repeat (2) tick();
    check("t6_one_load", loads - loads_before, 1);
    rx_byte(8'hC1, 1'b0, 1'b0);
    rx_byte(8'hC2, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_exp.delete();
    rx_exp.delete();
    exp_ovr = 1'b0;
    check("t6_tx_ready", tx_ready, 1);
    check("t6_rx_valid", rx_valid, 0);
    check("t6_load", load, 0);
    check("t6_overrun", rx_overrun, 0);
    loads_before = loads;
    repeat (40) tick();
    check("t6_no_loads", loads - loads_before, 0);
    tx_push(8'h99);
    wait_tx_idle();
    check("t6_new_load", loads - loads_before, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
